conv_window_mac: RTL
====================

# conv_window_mac

Convolution window MAC engine directly downstream of the weight input controller. Consumes the five latched weight-store rows (WS_RD_DATA_0..4, qualified by WS_FULL) and a stream of activation rows. Computes one signed R×S dot product plus bias per window, NUM_WINDOWS times per run, and emits each result on a ready/valid output port.

## Interface

Parameters:
- ACT_WIDTH, 8, width of one signed activation/weight element.
- WS_WIDTH, 40, row width; equals 5*ACT_WIDTH. Element s occupies bits [ACT_WIDTH*s +: ACT_WIDTH].
- ACC_WIDTH, 32, accumulator/output width, signed two's complement.

Ports:
- CLK  in  1  clock
- RESETN  in  1  reset, synchronous, active-low
- START  in  1  run request; acted on at the rising edge only
- PARAM_R  in  4  filter height, unsigned, legal 1..5
- PARAM_S  in  4  filter width, unsigned, legal 1..5
- NUM_WINDOWS  in  16  windows per run, unsigned, legal ≥1
- BIAS  in  ACC_WIDTH  signed bias loaded into the accumulator at each window start
- WS_FULL  in  1  weight store loaded
- WS_RD_DATA_0..4  in  WS_WIDTH each  weight rows r=0..4
- ACT_VALID  in  1  activation row valid
- ACT_READY  out  1  activation row accepted when high with ACT_VALID
- ACT_DATA  in  WS_WIDTH  activation row, same element packing as weights
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  downstream accepts result
- OUT_DATA  out  ACC_WIDTH  window result
- BUSY  out  1  high in any state except IDLE
- DONE  out  1  one-cycle pulse after the final window handshake
- PARAM_ERR  out  1  one-cycle pulse when START is rejected

## Operation

- Rising-edge detection: a start_prev register tracks START; start_rise = START & ~start_prev.
- States: IDLE, WAIT_WS, ACCUM, OUTPUT.
- IDLE, on start_rise:
  - If PARAM_R ∉ 1..5, PARAM_S ∉ 1..5, or NUM_WINDOWS == 0: pulse PARAM_ERR and stay in IDLE.
  - Otherwise latch R, S, NUM_WINDOWS and BIAS, then go to WAIT_WS.
- WAIT_WS: when WS_FULL == 1, set acc ← latched BIAS, row ← 0, win ← 0, and go to ACCUM.
  - WS_FULL is sampled only in this state. Weights must stay stable for the rest of the run.
- ACCUM: ACT_READY = 1.
  - On handshake, compute p = Σ_{s<S} act[s]·w_row[s]. Both operands are signed ACT_WIDTH; each product is 2·ACT_WIDTH bits; the sum is sign-extended to ACC_WIDTH.
  - w_row is WS_RD_DATA_<row>. Elements s ≥ S contribute 0 whatever their data.
  - acc ← acc + p, with wrap-around on overflow (no saturation).
  - If row == R−1, latch OUT_DATA ← acc + p and go to OUTPUT. Otherwise row ← row + 1.
- OUTPUT: OUT_VALID = 1. OUT_DATA is held stable until the handshake. On OUT_VALID & OUT_READY:
  - If win == NUM_WINDOWS−1: pulse DONE and go to IDLE.
  - Otherwise set win ← win + 1, acc ← BIAS, row ← 0, and go to ACCUM.
- START edges while not in IDLE are ignored. start_prev keeps tracking START, so a level still held at run end does not retrigger.
- Reset (any state, mid-run included): state IDLE; acc, row, win and start_prev cleared. All outputs go to 0: ACT_READY, OUT_VALID, OUT_DATA, BUSY, DONE, PARAM_ERR.

## Timing

- ACT_READY, OUT_VALID and BUSY are pure decodes of the registered state, with no combinational path from any input.
- START edge → BUSY high: 1 cycle. If WS_FULL is already high, ACT_READY goes high 2 cycles after the edge.
- Throughput: one activation row per cycle while ACT_VALID stays high. A window takes R cycles minimum.
- Last-row handshake at cycle t → OUT_VALID high at t+1.
- OUT handshake at cycle t → ACT_READY high at t+1. Minimum window period is R+1 cycles.
- DONE and PARAM_ERR are registered pulses, exactly 1 cycle wide, asserted the cycle after their cause.
- ACT_VALID gaps stall ACCUM with no state change. OUT_READY low holds OUTPUT indefinitely.

## Test plan

- R=S=3, all weights 1, activation row r = r+1 in all columns, columns 3–4 = 0x7F, BIAS=10, NUM_WINDOWS=1 → OUT_DATA=28 (0x1C), then DONE pulse, BUSY low.
- R=S=5, all weights and activations −128, BIAS=0 → OUT_DATA=409600 (0x00064000). Confirms 5 back-to-back ACT handshakes and OUT_VALID on the next cycle.
- NUM_WINDOWS=3, R=2, S=2, weights 1, activations per window k = k+1, OUT_READY low for 4 cycles on window 0 → outputs 4, 8, 12 in order. OUT_DATA stable while stalled; exactly one DONE.
- START with PARAM_R=0, then PARAM_S=6, then NUM_WINDOWS=0 → three PARAM_ERR pulses, BUSY stays 0. START held high after a valid run ends → no second run.
- WS_FULL low at START for 10 cycles → ACT_READY stays 0 until one cycle after WS_FULL rises. Random ACT_VALID gaps → result equal to the gap-free run.
- RESETN low for one cycle mid-window (after 2 of 3 rows) → all outputs 0 the next cycle. A new START yields a correct result with no residue from the aborted window.

Source files
------------

// File: rtl/conv_window_mac_if.sv
// Activation-row input stream and result output stream of the window MAC engine.
// The slave modport is the engine's view; the master modport is the producer/consumer side.
interface conv_window_mac_if #(
    parameter int WS_WIDTH  = 40,
    parameter int ACC_WIDTH = 32
);
    logic                 ACT_VALID;
    logic                 ACT_READY;
    logic [WS_WIDTH-1:0]  ACT_DATA;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [ACC_WIDTH-1:0] OUT_DATA;

    modport master (
        output ACT_VALID,
        output ACT_DATA,
        output OUT_READY,
        input  ACT_READY,
        input  OUT_VALID,
        input  OUT_DATA
    );

    modport slave (
        input  ACT_VALID,
        input  ACT_DATA,
        input  OUT_READY,
        output ACT_READY,
        output OUT_VALID,
        output OUT_DATA
    );
endinterface

// File: rtl/conv_window_mac.sv
// Convolution window MAC: per window, accumulates R activation rows dotted with the
// latched weight rows (first S elements) on top of a bias, then emits the sum.
module conv_window_mac #(
    parameter int ACT_WIDTH = 8,
    parameter int WS_WIDTH  = 40,
    parameter int ACC_WIDTH = 32
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        START,
    input  logic [3:0]                  PARAM_R,
    input  logic [3:0]                  PARAM_S,
    input  logic [15:0]                 NUM_WINDOWS,
    input  logic signed [ACC_WIDTH-1:0] BIAS,
    input  logic                        WS_FULL,
    input  logic [WS_WIDTH-1:0]         WS_RD_DATA_0,
    input  logic [WS_WIDTH-1:0]         WS_RD_DATA_1,
    input  logic [WS_WIDTH-1:0]         WS_RD_DATA_2,
    input  logic [WS_WIDTH-1:0]         WS_RD_DATA_3,
    input  logic [WS_WIDTH-1:0]         WS_RD_DATA_4,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        PARAM_ERR,
    conv_window_mac_if.slave            stream
);

    localparam int PROD_WIDTH = 2 * ACT_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WS = 2'd1,
        ACCUM   = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic                 start_prev_reg;
    logic [3:0]           r_reg, r_next;
    logic [3:0]           s_reg, s_next;
    logic [15:0]          nwin_reg, nwin_next;
    logic [ACC_WIDTH-1:0] bias_reg, bias_next;
    logic [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic [2:0]           row_reg, row_next;
    logic [15:0]          win_reg, win_next;
    logic [ACC_WIDTH-1:0] out_data_reg, out_data_next;
    logic                 done_reg, done_next;
    logic                 param_err_reg, param_err_next;

    logic                 start_rise;
    logic                 params_bad;
    logic                 last_row;
    logic [WS_WIDTH-1:0]  w_row;
    logic [ACC_WIDTH-1:0] term [5];
    logic [ACC_WIDTH-1:0] row_sum;
    logic [ACC_WIDTH-1:0] acc_sum;

    assign start_rise = START & ~start_prev_reg;
    assign params_bad = (PARAM_R == 4'd0) || (PARAM_R > 4'd5) ||
                        (PARAM_S == 4'd0) || (PARAM_S > 4'd5) ||
                        (NUM_WINDOWS == 16'd0);
    assign last_row   = ({1'b0, row_reg} == (r_reg - 4'd1));

    always_comb begin
        w_row = '0;
        case (row_reg)
            3'd0:    w_row = WS_RD_DATA_0;
            3'd1:    w_row = WS_RD_DATA_1;
            3'd2:    w_row = WS_RD_DATA_2;
            3'd3:    w_row = WS_RD_DATA_3;
            3'd4:    w_row = WS_RD_DATA_4;
            default: w_row = '0;
        endcase
    end

    // One signed product per column; columns at or beyond S are forced to zero.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_col
            localparam logic [3:0] IDX = 4'(gi);
            logic signed [ACT_WIDTH-1:0]  act_e;
            logic signed [ACT_WIDTH-1:0]  w_e;
            logic signed [PROD_WIDTH-1:0] prod;

            assign act_e = stream.ACT_DATA[ACT_WIDTH*gi +: ACT_WIDTH];
            assign w_e   = w_row[ACT_WIDTH*gi +: ACT_WIDTH];
            assign prod  = act_e * w_e;
            assign term[gi] = (IDX < s_reg)
                ? {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod}
                : '0;
        end
    endgenerate

    assign row_sum = term[0] + term[1] + term[2] + term[3] + term[4];
    assign acc_sum = acc_reg + row_sum;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_reg      <= IDLE;
            start_prev_reg <= 1'b0;
            r_reg          <= '0;
            s_reg          <= '0;
            nwin_reg       <= '0;
            bias_reg       <= '0;
            acc_reg        <= '0;
            row_reg        <= '0;
            win_reg        <= '0;
            out_data_reg   <= '0;
            done_reg       <= 1'b0;
            param_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_prev_reg <= START;
            r_reg          <= r_next;
            s_reg          <= s_next;
            nwin_reg       <= nwin_next;
            bias_reg       <= bias_next;
            acc_reg        <= acc_next;
            row_reg        <= row_next;
            win_reg        <= win_next;
            out_data_reg   <= out_data_next;
            done_reg       <= done_next;
            param_err_reg  <= param_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        r_next         = r_reg;
        s_next         = s_reg;
        nwin_next      = nwin_reg;
        bias_next      = bias_reg;
        acc_next       = acc_reg;
        row_next       = row_reg;
        win_next       = win_reg;
        out_data_next  = out_data_reg;
        done_next      = 1'b0;
        param_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_rise) begin
                    if (params_bad) begin
                        param_err_next = 1'b1;
                    end else begin
                        r_next     = PARAM_R;
                        s_next     = PARAM_S;
                        nwin_next  = NUM_WINDOWS;
                        bias_next  = BIAS;
                        state_next = WAIT_WS;
                    end
                end
            end
            WAIT_WS: begin
                if (WS_FULL) begin
                    acc_next   = bias_reg;
                    row_next   = '0;
                    win_next   = '0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (stream.ACT_VALID) begin
                    acc_next = acc_sum;
                    if (last_row) begin
                        out_data_next = acc_sum;
                        state_next    = OUTPUT;
                    end else begin
                        row_next = row_reg + 3'd1;
                    end
                end
            end
            OUTPUT: begin
                if (stream.OUT_READY) begin
                    if (win_reg == (nwin_reg - 16'd1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        win_next   = win_reg + 16'd1;
                        acc_next   = bias_reg;
                        row_next   = '0;
                        state_next = ACCUM;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake strobes decode the state register only, so no input reaches them combinationally.
    assign stream.ACT_READY = (state_reg == ACCUM);
    assign stream.OUT_VALID = (state_reg == OUTPUT);
    assign stream.OUT_DATA  = out_data_reg;
    assign BUSY             = (state_reg != IDLE);
    assign DONE             = done_reg;
    assign PARAM_ERR        = param_err_reg;

endmodule
